fib_bcd_conv: RTL

FIB_BCD_CONV -- requirements
Module: fib_bcd_conv

---
 rtl/fib_bcd_conv_if.sv | 12 +
 rtl/fib_bcd_conv.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fib_bcd_conv_if.sv
// Handshake/result bundle for fib_bcd_conv: upstream value and level-valid in, BCD result out.
interface fib_bcd_conv_if;
    logic        in_en;
    logic [19:0] in_data;
    logic        busy;
    logic [27:0] bcd;
    logic [2:0]  ndigits;
    logic        bcd_valid;

    modport master (output in_en, in_data, input busy, bcd, ndigits, bcd_valid);
    modport slave  (input in_en, in_data, output busy, bcd, ndigits, bcd_valid);
endinterface

// File: rtl/fib_bcd_conv.sv
// 20-bit binary to 7-digit packed BCD converter (shift-add-3), triggered on the rising edge of in_en.
// Optional build macro FIB_BCD_BLANK_EN drives leading zero digits as 4'hF instead of 4'h0.
module fib_bcd_conv (
    input  logic           clk,
    input  logic           reset_n,
    fib_bcd_conv_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_in_en_d;
    logic [19:0] r_sr;
    logic [27:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic [27:0] r_bcd;
    logic [2:0]  r_ndigits;
    logic        r_bcd_valid;
    logic        w_trigger;
    logic [27:0] w_adj;

    function automatic logic [27:0] f_add3(input logic [27:0] acc);
        logic [27:0] res;
        res = acc;
        for (int i = 0; i < 7; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Digit count is the position of the highest nonzero digit plus one; zero counts as one digit.
    function automatic logic [2:0] f_ndigits(input logic [27:0] acc);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 1; i < 7; i++) begin
            if (acc[4*i +: 4] != 4'd0) begin
                n = 3'(i + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    function automatic logic [27:0] f_present(input logic [27:0] acc);
        logic [27:0] res;
        res = acc;
`ifdef FIB_BCD_BLANK_EN
        for (int i = 1; i < 7; i++) begin
            if (i >= int'(f_ndigits(acc))) begin
                res[4*i +: 4] = 4'hF;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
`endif
        return res;
    endfunction

    assign w_trigger = bus.in_en & ~r_in_en_d;
    assign w_adj     = f_add3(r_acc);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; triggers outside IDLE are dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == 5'd19) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: edge detect, shift-add-3 iteration and registered result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_en_d   <= 1'b0;
            r_sr        <= 20'd0;
            r_acc       <= 28'd0;
            r_cnt       <= 5'd0;
            r_busy      <= 1'b0;
            r_bcd       <= 28'd0;
            r_ndigits   <= 3'd1;
            r_bcd_valid <= 1'b0;
        end else begin
            r_in_en_d   <= bus.in_en;
            r_busy      <= (w_next_state != ST_IDLE);
            r_bcd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_sr  <= bus.in_data;
                        r_acc <= 28'd0;
                        r_cnt <= 5'd0;
                    end
                end
                ST_SHIFT: begin
                    {r_acc, r_sr} <= {w_adj[26:0], r_sr, 1'b0};
                    r_cnt         <= r_cnt + 5'd1;
                end
                ST_DONE: begin
                    r_bcd       <= f_present(r_acc);
                    r_ndigits   <= f_ndigits(r_acc);
                    r_bcd_valid <= 1'b1;
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.bcd       = r_bcd;
    assign bus.ndigits   = r_ndigits;
    assign bus.bcd_valid = r_bcd_valid;

endmodule
